// File: rtl/alarm_time_ctrl_pkg.sv
// Shared timer definitions: field widths, wrap limits, edit/ring state encodings
// and the field-increment helpers used by the alarm editor.
package alarm_time_ctrl_pkg;

    localparam int HOUR_W   = 5;
    localparam int MIN_W    = 6;
    localparam int SEC_W    = 6;
    localparam int MAX_HOUR = 23;
    localparam int MAX_MIN  = 59;

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } edit_mode_e;

    typedef enum logic {
        IDLE    = 1'b0,
        RINGING = 1'b1
    } ring_state_e;

    // Hour increment with 23 -> 0 wrap; anything out of range also folds to 0.
    function automatic logic [HOUR_W-1:0] next_hour(input logic [HOUR_W-1:0] hour_v);
        if (hour_v >= HOUR_W'(MAX_HOUR)) begin
            return 5'd0;
        end else begin
            return hour_v + 5'd1;
        end
    endfunction

    // Minute increment with 59 -> 0 wrap.
    function automatic logic [MIN_W-1:0] next_min(input logic [MIN_W-1:0] min_v);
        if (min_v >= MIN_W'(MAX_MIN)) begin
            return 6'd0;
        end else begin
            return min_v + 6'd1;
        end
    endfunction

endpackage

// File: rtl/alarm_time_ctrl_btn_edge_det.sv
// Registered rising-edge detector for a debounced button level: one pulse per press.
module btn_edge_det (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic rise
);

    logic btn_q_r;

    // Previous-cycle copy of the button level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_q_r <= 1'b0;
        end else begin
            btn_q_r <= btn;
        end
    end

    assign rise = btn & ~btn_q_r;

endmodule

// File: rtl/alarm_time_ctrl.sv
// Alarm time register with set/increment editor, time comparator and ring-window FSM;
// MATCH stays high for RING_SECS seconds after the clock reaches the alarm time.
module alarm_time_ctrl
    import alarm_time_ctrl_pkg::*;
#(
    parameter int unsigned RESET_HOUR = 7,
    parameter int unsigned RESET_MIN  = 0,
    parameter int unsigned RING_SECS  = 30
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sec_tick,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_min,
    input  logic [SEC_W-1:0]  cur_sec,
    input  logic              set_btn,
    input  logic              inc_btn,
    input  logic              stop_btn,
    output logic [HOUR_W-1:0] alarm_hour,
    output logic [MIN_W-1:0]  alarm_min,
    output logic [1:0]        edit_mode,
    output logic              MATCH
);

    localparam logic [HOUR_W-1:0] HOUR_RST = HOUR_W'(RESET_HOUR);
    localparam logic [MIN_W-1:0]  MIN_RST  = MIN_W'(RESET_MIN);
    localparam logic [6:0]        RING_END = 7'(RING_SECS);

    logic set_edge_s;
    logic inc_edge_s;
    logic stop_edge_s;

    edit_mode_e        edit_state_r;
    edit_mode_e        edit_state_s;
    logic [HOUR_W-1:0] alarm_hour_r;
    logic [HOUR_W-1:0] alarm_hour_s;
    logic [MIN_W-1:0]  alarm_min_r;
    logic [MIN_W-1:0]  alarm_min_s;

    logic eq_s;
    logic eq_q_r;
    logic trigger_s;

    ring_state_e ring_state_r;
    ring_state_e ring_state_s;
    logic [5:0]  ring_cnt_r;
    logic [5:0]  ring_cnt_s;
    logic        match_r;

    btn_edge_det u_set_edge  (.clk(clk), .reset_n(reset_n), .btn(set_btn),  .rise(set_edge_s));
    btn_edge_det u_inc_edge  (.clk(clk), .reset_n(reset_n), .btn(inc_btn),  .rise(inc_edge_s));
    btn_edge_det u_stop_edge (.clk(clk), .reset_n(reset_n), .btn(stop_btn), .rise(stop_edge_s));

    // Edit FSM: increment lands on the field of the current state before set advances it.
    always_comb begin
        edit_state_s = edit_state_r;
        alarm_hour_s = alarm_hour_r;
        alarm_min_s  = alarm_min_r;
        case (edit_state_r)
            NORMAL: begin
                if (set_edge_s) begin
                    edit_state_s = SET_HOUR;
                end else begin
                    edit_state_s = NORMAL;
                end
            end
            SET_HOUR: begin
                if (inc_edge_s) begin
                    alarm_hour_s = next_hour(alarm_hour_r);
                end else begin
                    alarm_hour_s = alarm_hour_r;
                end
                if (set_edge_s) begin
                    edit_state_s = SET_MIN;
                end else begin
                    edit_state_s = SET_HOUR;
                end
            end
            SET_MIN: begin
                if (inc_edge_s) begin
                    alarm_min_s = next_min(alarm_min_r);
                end else begin
                    alarm_min_s = alarm_min_r;
                end
                if (set_edge_s) begin
                    edit_state_s = NORMAL;
                end else begin
                    edit_state_s = SET_MIN;
                end
            end
            default: begin
                edit_state_s = NORMAL;
            end
        endcase
    end

    // Only the rising edge of eq fires, so a whole matching second rings once.
    assign eq_s = (cur_hour == alarm_hour_r) && (cur_min == alarm_min_r) &&
                  (cur_sec == 6'd0) && (edit_state_r == NORMAL);
    assign trigger_s = eq_s & ~eq_q_r;

    // Ring FSM: stop or set edges override both the trigger and the tick count.
    always_comb begin
        ring_state_s = ring_state_r;
        ring_cnt_s   = ring_cnt_r;
        case (ring_state_r)
            IDLE: begin
                if (trigger_s && !stop_edge_s && !set_edge_s) begin
                    ring_state_s = RINGING;
                    ring_cnt_s   = 6'd0;
                end else begin
                    ring_state_s = IDLE;
                end
            end
            RINGING: begin
                if (stop_edge_s || set_edge_s) begin
                    ring_state_s = IDLE;
                    ring_cnt_s   = 6'd0;
                end else if (sec_tick) begin
                    if (({1'b0, ring_cnt_r} + 7'd1) == RING_END) begin
                        ring_state_s = IDLE;
                        ring_cnt_s   = 6'd0;
                    end else begin
                        ring_cnt_s = ring_cnt_r + 6'd1;
                    end
                end else begin
                    ring_state_s = RINGING;
                end
            end
            default: begin
                ring_state_s = IDLE;
                ring_cnt_s   = 6'd0;
            end
        endcase
    end

    // State and field registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edit_state_r <= NORMAL;
            alarm_hour_r <= HOUR_RST;
            alarm_min_r  <= MIN_RST;
            eq_q_r       <= 1'b0;
            ring_state_r <= IDLE;
            ring_cnt_r   <= 6'd0;
            match_r      <= 1'b0;
        end else begin
            edit_state_r <= edit_state_s;
            alarm_hour_r <= alarm_hour_s;
            alarm_min_r  <= alarm_min_s;
            eq_q_r       <= eq_s;
            ring_state_r <= ring_state_s;
            ring_cnt_r   <= ring_cnt_s;
            match_r      <= (ring_state_s == RINGING);
        end
    end

    assign alarm_hour = alarm_hour_r;
    assign alarm_min  = alarm_min_r;
    assign edit_mode  = edit_state_r;
    assign MATCH      = match_r;

endmodule

// File: tb/tb_alarm_time_ctrl.sv
// Directed bench for alarm_time_ctrl: editing, ring window, stop, edit-vs-match and async reset.
module tb_alarm_time_ctrl;

    logic       clk;
    logic       reset_n;
    logic       sec_tick;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic [5:0] cur_sec;
    logic       set_btn;
    logic       inc_btn;
    logic       stop_btn;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;
    logic [1:0] edit_mode;
    logic       MATCH;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    alarm_time_ctrl dut (
        .clk(clk), .reset_n(reset_n), .sec_tick(sec_tick),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .set_btn(set_btn), .inc_btn(inc_btn), .stop_btn(stop_btn),
        .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .edit_mode(edit_mode), .MATCH(MATCH)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_time(input int h, input int m, input int s);
        cur_hour = 5'(h);
        cur_min  = 6'(m);
        cur_sec  = 6'(s);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // One-cycle press; returns two clock edges later at a negedge.
    task automatic press_set();
        set_btn = 1'b1;
        @(negedge clk);
        set_btn = 1'b0;
        @(negedge clk);
    endtask

    task automatic press_inc(input int n);
        for (int i = 0; i < n; i++) begin
            inc_btn = 1'b1;
            @(negedge clk);
            inc_btn = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic tick(input int s);
        sec_tick = 1'b1;
        cur_sec  = 6'(s);
        @(negedge clk);
        sec_tick = 1'b0;
    endtask

    task automatic test_reset();
        set_time(12, 30, 30);
        do_reset();
        chk_cnt++; if (alarm_hour !== 5'd7) $display("FAIL reset_hour got=%0d exp=7", alarm_hour); else pass_cnt++;
        chk_cnt++; if (alarm_min !== 6'd0) $display("FAIL reset_min got=%0d exp=0", alarm_min); else pass_cnt++;
        chk_cnt++; if (edit_mode !== 2'd0) $display("FAIL reset_mode got=%0d exp=0", edit_mode); else pass_cnt++;
        chk_cnt++; if (MATCH !== 1'b0) $display("FAIL reset_match got=%0b exp=0", MATCH); else pass_cnt++;
    endtask

    task automatic test_edit();
        set_time(12, 30, 30);
        do_reset();
        press_inc(1);
        chk_cnt++; if (alarm_hour !== 5'd7) $display("FAIL inc_in_normal got=%0d exp=7", alarm_hour); else pass_cnt++;
        press_set();
        chk_cnt++; if (edit_mode !== 2'd1) $display("FAIL mode_set_hour got=%0d exp=1", edit_mode); else pass_cnt++;
        press_inc(10);
        chk_cnt++; if (alarm_hour !== 5'd17) $display("FAIL hour_7p10 got=%0d exp=17", alarm_hour); else pass_cnt++;
        press_inc(7);
        chk_cnt++; if (alarm_hour !== 5'd0) $display("FAIL hour_wrap got=%0d exp=0", alarm_hour); else pass_cnt++;
        press_inc(17);
        chk_cnt++; if (alarm_hour !== 5'd17) $display("FAIL hour_0p17 got=%0d exp=17", alarm_hour); else pass_cnt++;
        press_set();
        chk_cnt++; if (edit_mode !== 2'd2) $display("FAIL mode_set_min got=%0d exp=2", edit_mode); else pass_cnt++;
        press_inc(61);
        chk_cnt++; if (alarm_min !== 6'd1) $display("FAIL min_wrap got=%0d exp=1", alarm_min); else pass_cnt++;
        chk_cnt++; if (alarm_hour !== 5'd17) $display("FAIL hour_kept got=%0d exp=17", alarm_hour); else pass_cnt++;
        press_set();
        chk_cnt++; if (edit_mode !== 2'd0) $display("FAIL mode_normal got=%0d exp=0", edit_mode); else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        set_time(12, 30, 30);
        do_reset();
        press_set();
        set_btn = 1'b1;
        inc_btn = 1'b1;
        @(negedge clk);
        set_btn = 1'b0;
        inc_btn = 1'b0;
        @(negedge clk);
        chk_cnt++; if (alarm_hour !== 5'd8) $display("FAIL set_inc_hour got=%0d exp=8", alarm_hour); else pass_cnt++;
        chk_cnt++; if (alarm_min !== 6'd0) $display("FAIL set_inc_min got=%0d exp=0", alarm_min); else pass_cnt++;
        chk_cnt++; if (edit_mode !== 2'd2) $display("FAIL set_inc_mode got=%0d exp=2", edit_mode); else pass_cnt++;
        inc_btn = 1'b1;
        repeat (5) @(negedge clk);
        inc_btn = 1'b0;
        @(negedge clk);
        chk_cnt++; if (alarm_min !== 6'd1) $display("FAIL held_inc got=%0d exp=1", alarm_min); else pass_cnt++;
        press_set();
    endtask

    task automatic test_ring();
        set_time(12, 30, 30);
        do_reset();
        set_time(6, 59, 59);
        repeat (2) @(negedge clk);
        chk_cnt++; if (MATCH !== 1'b0) $display("FAIL ring_before got=%0b exp=0", MATCH); else pass_cnt++;
        set_time(7, 0, 0);
        @(negedge clk);
        chk_cnt++; if (MATCH !== 1'b1) $display("FAIL ring_rise got=%0b exp=1", MATCH); else pass_cnt++;
        for (int k = 1; k <= 59; k++) begin
            tick(k);
            chk_cnt++;
            if (MATCH !== (k < 30)) $display("FAIL ring_tick%0d got=%0b exp=%0b", k, MATCH, (k < 30));
            else pass_cnt++;
            @(negedge clk);
        end
        set_time(7, 1, 0);
        @(negedge clk);
        chk_cnt++; if (MATCH !== 1'b0) $display("FAIL ring_next_min got=%0b exp=0", MATCH); else pass_cnt++;
    endtask

    task automatic test_stop();
        set_time(12, 30, 30);
        do_reset();
        set_time(6, 59, 59);
        repeat (2) @(negedge clk);
        set_time(7, 0, 0);
        @(negedge clk);
        chk_cnt++; if (MATCH !== 1'b1) $display("FAIL stop_rise got=%0b exp=1", MATCH); else pass_cnt++;
        for (int k = 1; k <= 4; k++) begin
            tick(k);
            @(negedge clk);
        end
        chk_cnt++; if (MATCH !== 1'b1) $display("FAIL stop_pre got=%0b exp=1", MATCH); else pass_cnt++;
        stop_btn = 1'b1;
        tick(5);
        stop_btn = 1'b0;
        chk_cnt++; if (MATCH !== 1'b0) $display("FAIL stop_tick5 got=%0b exp=0", MATCH); else pass_cnt++;
        repeat (3) @(negedge clk);
        chk_cnt++; if (MATCH !== 1'b0) $display("FAIL stop_stays got=%0b exp=0", MATCH); else pass_cnt++;
        set_time(6, 0, 0);
        repeat (2) @(negedge clk);
        set_time(7, 0, 0);
        stop_btn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            stop_btn = 1'b0;
            chk_cnt++;
            if (MATCH !== 1'b0) $display("FAIL stop_with_trigger c%0d got=%0b exp=0", c, MATCH);
            else pass_cnt++;
        end
    endtask

    task automatic test_edit_match();
        set_time(12, 30, 30);
        do_reset();
        press_set();
        press_inc(1);
        press_set();
        press_inc(15);
        chk_cnt++; if (alarm_hour !== 5'd8 || alarm_min !== 6'd15)
            $display("FAIL edit_0815 got=%0d:%0d exp=8:15", alarm_hour, alarm_min); else pass_cnt++;
        set_time(8, 15, 0);
        repeat (3) @(negedge clk);
        chk_cnt++; if (MATCH !== 1'b0) $display("FAIL match_in_edit got=%0b exp=0", MATCH); else pass_cnt++;
        set_time(8, 15, 20);
        press_set();
        repeat (2) @(negedge clk);
        chk_cnt++; if (edit_mode !== 2'd0) $display("FAIL leave_edit_mode got=%0d exp=0", edit_mode); else pass_cnt++;
        chk_cnt++; if (MATCH !== 1'b0) $display("FAIL leave_edit_sec20 got=%0b exp=0", MATCH); else pass_cnt++;
        set_time(8, 15, 0);
        press_set();
        press_set();
        chk_cnt++; if (MATCH !== 1'b0) $display("FAIL reenter_edit got=%0b exp=0", MATCH); else pass_cnt++;
        press_set();
        chk_cnt++; if (MATCH !== 1'b1) $display("FAIL leave_edit_sec0 got=%0b exp=1", MATCH); else pass_cnt++;
    endtask

    task automatic test_reset_mid_ring();
        set_time(12, 30, 30);
        do_reset();
        press_set();
        press_inc(1);
        press_set();
        press_set();
        set_time(8, 0, 0);
        @(negedge clk);
        chk_cnt++; if (MATCH !== 1'b1) $display("FAIL rst_ring_rise got=%0b exp=1", MATCH); else pass_cnt++;
        tick(1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_cnt++; if (MATCH !== 1'b0) $display("FAIL rst_async_match got=%0b exp=0", MATCH); else pass_cnt++;
        chk_cnt++; if (alarm_hour !== 5'd7 || alarm_min !== 6'd0)
            $display("FAIL rst_async_alarm got=%0d:%0d exp=7:0", alarm_hour, alarm_min); else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_cnt++; if (MATCH !== 1'b0) $display("FAIL rst_after got=%0b exp=0", MATCH); else pass_cnt++;
    endtask

    initial begin
        reset_n  = 1'b1;
        sec_tick = 1'b0;
        set_btn  = 1'b0;
        inc_btn  = 1'b0;
        stop_btn = 1'b0;
        set_time(12, 30, 30);
        test_reset();
        test_edit();
        test_simultaneous();
        test_ring();
        test_stop();
        test_edit_match();
        test_reset_mid_ring();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
